sdp_bank_ram: RTL and testbench

SDP_BANK_RAM -- requirements
Module: sdp_bank_ram

---
 rtl/sdp_bank_ram.sv | 117 +++++++++++
 tb/tb_sdp_bank_ram.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_bank_ram.sv
// sdp_bank_ram: a set of independent simple-dual-port RAM banks sharing one clock.
// Each bank has a byte-column write port and a pipelined read port.
// The read pipeline depth is 1 or 2 cycles.
// Same-address read/write collisions are selectable as write-first or read-first.
// The memory array is never touched by reset. Only the read pipeline is cleared.
module sdp_bank_ram #(
    parameter int NUM_BANK   = 4,
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int BANK_DEPTH = 512,
    parameter int RD_LATENCY = 2,
    parameter int BYPASS     = 1,
    parameter     RAM_TYPE   = "block",
    localparam int DW = NB_COL * COL_WIDTH,
    localparam int AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_BANK*NB_COL-1:0]   wr_en,
    input  logic [NUM_BANK*AW-1:0]       wr_addr,
    input  logic [NUM_BANK*DW-1:0]       wr_data,
    input  logic [NUM_BANK-1:0]          rd_en,
    input  logic [NUM_BANK*AW-1:0]       rd_addr,
    output logic [NUM_BANK*DW-1:0]       rd_data,
    output logic [NUM_BANK-1:0]          rd_valid
);

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [NB_COL-1:0] wr_en_b;
        logic [AW-1:0]     wr_addr_b;
        logic [DW-1:0]     wr_data_b;
        logic              rd_en_b;
        logic [AW-1:0]     rd_addr_b;
        logic              wr_ok;
        logic              collide;
        logic [DW-1:0]     rd_word_d;
        logic              s1_valid_q;
        logic [DW-1:0]     s1_data_q;

        // Contents start at zero and are deliberately left out of the reset domain.
        (* ram_style = RAM_TYPE *) logic [DW-1:0] mem [BANK_DEPTH] = '{default: '0};

        assign wr_en_b   = wr_en[b*NB_COL +: NB_COL];
        assign wr_addr_b = wr_addr[b*AW +: AW];
        assign wr_data_b = wr_data[b*DW +: DW];
        assign rd_en_b   = rd_en[b];
        assign rd_addr_b = rd_addr[b*AW +: AW];

        // Out-of-range write addresses are dropped so they cannot alias onto legal words.
        if (BANK_DEPTH == (1 << AW)) begin : g_full
            assign wr_ok = 1'b1;
        end else begin : g_partial
            assign wr_ok = (32'(wr_addr_b) < BANK_DEPTH);
        end

        assign collide = rd_en_b && (|wr_en_b) && wr_ok && (wr_addr_b == rd_addr_b);

        // Column-masked write. It runs even while rst_n is low.
        always_ff @(posedge clk) begin
            for (int c = 0; c < NB_COL; c++) begin
                if (wr_en_b[c] && wr_ok) begin
                    mem[wr_addr_b][c*COL_WIDTH +: COL_WIDTH] <= wr_data_b[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end

        // Array read. In write-first mode, enabled columns are forwarded from the same-edge write.
        always_comb begin
            rd_word_d = mem[rd_addr_b];
            if (BYPASS != 0 && collide) begin
                for (int c = 0; c < NB_COL; c++) begin
                    if (wr_en_b[c]) begin
                        rd_word_d[c*COL_WIDTH +: COL_WIDTH] = wr_data_b[c*COL_WIDTH +: COL_WIDTH];
                    end
                end
            end
        end

        // First read stage. Data is captured only on a request so it holds between reads.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_en_b;
                if (rd_en_b) begin
                    s1_data_q <= rd_word_d;
                end
            end
        end

        if (RD_LATENCY == 1) begin : g_lat1
            assign rd_valid[b]           = s1_valid_q;
            assign rd_data[b*DW +: DW]   = s1_data_q;
        end else begin : g_lat2
            logic          out_valid_q;
            logic [DW-1:0] out_data_q;

            // Second read stage. It advances only valid words so rd_data holds while idle.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        out_data_q <= s1_data_q;
                    end
                end
            end

            assign rd_valid[b]         = out_valid_q;
            assign rd_data[b*DW +: DW] = out_data_q;
        end
    end

endmodule

// File: tb/tb_sdp_bank_ram.sv
// Testbench for sdp_bank_ram.
// Three instances are used: write-first with latency 2, read-first with latency 2, and write-first with latency 1.
// A reference memory model and per-bank expected queues check data, order and exact read latency.
module tb_sdp_bank_ram;

    localparam int NI = 3;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int DEPTH = 512;
    localparam int LAT [NI] = '{2, 2, 1};
    localparam int BP  [NI] = '{1, 0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NB*4-1:0]  wr_en_s   [NI];
    logic [NB*AW-1:0] wr_addr_s [NI];
    logic [NB*DW-1:0] wr_data_s [NI];
    logic [NB-1:0]    rd_en_s   [NI];
    logic [NB*AW-1:0] rd_addr_s [NI];
    logic [NB*DW-1:0] rd_data_s [NI];
    logic [NB-1:0]    rd_valid_s[NI];

    sdp_bank_ram u_dut_wf (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0]),
        .rd_en(rd_en_s[0]), .rd_addr(rd_addr_s[0]),
        .rd_data(rd_data_s[0]), .rd_valid(rd_valid_s[0])
    );

    sdp_bank_ram #(.BYPASS(0)) u_dut_rf (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1]),
        .rd_en(rd_en_s[1]), .rd_addr(rd_addr_s[1]),
        .rd_data(rd_data_s[1]), .rd_valid(rd_valid_s[1])
    );

    sdp_bank_ram #(.RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en_s[2]), .wr_addr(wr_addr_s[2]), .wr_data(wr_data_s[2]),
        .rd_en(rd_en_s[2]), .rd_addr(rd_addr_s[2]),
        .rd_data(rd_data_s[2]), .rd_valid(rd_valid_s[2])
    );

    // ---------------- clock counter, model, scoreboard state ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] model   [NI][NB][DEPTH];
    logic [3:0]    pw_be   [NI][NB];
    logic [AW-1:0] pw_addr [NI][NB];
    logic [DW-1:0] pw_data [NI][NB];

    logic [DW-1:0] exp_q [NI][NB][$];
    int            due_q [NI][NB][$];

    logic [DW-1:0] mon_e;
    int            mon_d;

    // Scoreboard: every valid word must match the oldest expectation and arrive exactly on its due cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (rd_valid_s[i][b] === 1'b1) begin
                    compared++;
                    if (exp_q[i][b].size() == 0) begin
                        mismatched++;
                        $display("FAIL rd_valid_unexpected inst%0d bank%0d cyc %0d: got valid=1 data=%h, want valid=0",
                                 i, b, cyc, rd_data_s[i][b*DW +: DW]);
                    end else begin
                        mon_e = exp_q[i][b].pop_front();
                        mon_d = due_q[i][b].pop_front();
                        if (rd_data_s[i][b*DW +: DW] !== mon_e || cyc != mon_d) begin
                            mismatched++;
                            $display("FAIL rd_data inst%0d bank%0d: got %h at cyc %0d, want %h at cyc %0d",
                                     i, b, rd_data_s[i][b*DW +: DW], cyc, mon_e, mon_d);
                        end
                    end
                end else if (exp_q[i][b].size() != 0 && cyc > due_q[i][b][0]) begin
                    compared++;
                    mismatched++;
                    mon_e = exp_q[i][b].pop_front();
                    mon_d = due_q[i][b].pop_front();
                    $display("FAIL rd_valid_missing inst%0d bank%0d: got valid=%b at cyc %0d, want 1 at cyc %0d (data %h)",
                             i, b, rd_valid_s[i][b], cyc, mon_d, mon_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clr_inputs();
        for (int i = 0; i < NI; i++) begin
            wr_en_s[i] = '0;
            rd_en_s[i] = '0;
        end
    endtask

    task automatic wr(input int i, input int b, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be);
        wr_en_s[i][b*4 +: 4]     = be;
        wr_addr_s[i][b*AW +: AW] = a;
        wr_data_s[i][b*DW +: DW] = d;
        pw_be[i][b]   = be;
        pw_addr[i][b] = a;
        pw_data[i][b] = d;
    endtask

    // A read must be issued after any write to the same bank in the same cycle.
    task automatic rd(input int i, input int b, input logic [AW-1:0] a, input bit track);
        logic [DW-1:0] e;
        e = model[i][b][a];
        if (BP[i] != 0 && pw_be[i][b] != 4'b0 && pw_addr[i][b] == a) begin
            for (int c = 0; c < 4; c++) begin
                if (pw_be[i][b][c]) e[c*8 +: 8] = pw_data[i][b][c*8 +: 8];
            end
        end
        rd_en_s[i][b]            = 1'b1;
        rd_addr_s[i][b*AW +: AW] = a;
        if (track) begin
            exp_q[i][b].push_back(e);
            due_q[i][b].push_back(cyc + LAT[i]);
        end
    endtask

    // One clock edge: commit pending writes to the model, then return idle at the falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) begin
                for (int c = 0; c < 4; c++) begin
                    if (pw_be[i][b][c]) model[i][b][pw_addr[i][b]][c*8 +: 8] = pw_data[i][b][c*8 +: 8];
                end
                pw_be[i][b] = 4'b0;
            end
        end
        @(negedge clk);
        clr_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) begin
                compared++;
                if (rd_valid_s[i][b] !== 1'b0 || rd_data_s[i][b*DW +: DW] !== '0) begin
                    mismatched++;
                    $display("FAIL reset_state inst%0d bank%0d: got valid=%b data=%h, want valid=0 data=0",
                             i, b, rd_valid_s[i][b], rd_data_s[i][b*DW +: DW]);
                end
            end
        end
        rst_n = 1'b1;
        // Memory must power up as zero.
        for (int i = 0; i < NI; i++) rd(i, 0, 9'd100, 1'b1);
        step();
        repeat (3) step();
    endtask

    task automatic test_basic();
        wr(0, 0, 9'd5, 32'hDEADBEEF, 4'hF);
        step();
        rd(0, 0, 9'd5, 1'b1);
        repeat (4) step();
        compared++;
        if (rd_data_s[0][31:0] !== 32'hDEADBEEF || rd_valid_s[0] !== 4'b0) begin
            mismatched++;
            $display("FAIL data_hold: got data=%h valid=%b, want data=deadbeef valid=0000",
                     rd_data_s[0][31:0], rd_valid_s[0]);
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < NI; i++) wr(i, 1, 9'd7, 32'h11223344, 4'hF);
        step();
        for (int i = 0; i < NI; i++) begin
            wr(i, 1, 9'd7, 32'hAABBCCDD, 4'b0101);
            rd(i, 1, 9'd7, 1'b1);
        end
        step();
        for (int i = 0; i < NI; i++) rd(i, 1, 9'd7, 1'b1);
        step();
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NI; i++) wr(i, 2, AW'(k), DW'(32'h100 + k), 4'hF);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NI; i++) rd(i, 2, AW'(k), 1'b1);
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < NI; i++) wr(i, 1, 9'd20, DW'(32'h20200000 + i), 4'hF);
        step();
        for (int i = 0; i < NI; i++) wr(i, 1, 9'd21, DW'(32'h21210000 + i), 4'hF);
        step();
        // Only the latency-1 instance completes the first read before reset lands.
        for (int i = 0; i < NI; i++) rd(i, 1, 9'd20, LAT[i] == 1);
        step();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            wr(i, 1, 9'd22, DW'(32'hCAFE0000 + i), 4'hF);
            rd(i, 1, 9'd21, 1'b0);
        end
        step();
        for (int i = 0; i < NI; i++) begin
            compared++;
            if (rd_valid_s[i][1] !== 1'b0 || rd_data_s[i][DW +: DW] !== '0) begin
                mismatched++;
                $display("FAIL reset_flush inst%0d: got valid=%b data=%h, want valid=0 data=0",
                         i, rd_valid_s[i][1], rd_data_s[i][DW +: DW]);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) rd(i, 1, 9'd21, 1'b1);
        step();
        for (int i = 0; i < NI; i++) rd(i, 1, 9'd20, 1'b1);
        step();
        for (int i = 0; i < NI; i++) rd(i, 1, 9'd22, 1'b1);
        step();
        repeat (3) step();
    endtask

    task automatic test_banks();
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) wr(i, b, 9'd3, {8'hB0 + 8'(b), 8'(i), 16'h5A5A}, 4'hF);
        end
        step();
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) rd(i, b, 9'd3, 1'b1);
        end
        step();
        repeat (3) step();
    endtask

    task automatic test_random();
        repeat (300) begin
            for (int i = 0; i < NI; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if ($urandom_range(0, 1) == 1)
                        wr(i, b, AW'($urandom_range(0, 15)), DW'($urandom), 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 2) != 0)
                        rd(i, b, AW'($urandom_range(0, 15)), 1'b1);
                end
            end
            step();
        end
        repeat (4) step();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) begin
                pw_be[i][b] = 4'b0;
                pw_addr[i][b] = '0;
                pw_data[i][b] = '0;
                for (int a = 0; a < DEPTH; a++) model[i][b][a] = '0;
            end
            wr_addr_s[i] = '0;
            wr_data_s[i] = '0;
            rd_addr_s[i] = '0;
        end
        clr_inputs();
        test_reset();
        test_basic();
        test_collision();
        test_back_to_back();
        test_reset_flush();
        test_banks();
        test_random();
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) begin
                compared++;
                if (exp_q[i][b].size() != 0) begin
                    mismatched++;
                    $display("FAIL drain inst%0d bank%0d: got %0d reads outstanding, want 0",
                             i, b, exp_q[i][b].size());
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
